// File: rtl/mdc_commutator.sv
// mdc_commutator: delay-switch-delay commutator for the 32-point MDC FFT.
// Reorders a 4-lane complex stream ({lane3,lane2,lane1,lane0}, nb bits per
// lane) so each butterfly pair sees samples DEPTH apart. Lanes 0/1 are pair A,
// lanes 2/3 are pair B; both pairs share one index counter.
// Optional: define MDC_COMM_BYPASS_EN to add a BYPASS input that routes IR/II
// straight to the output register.

// One pair (upper/lower lane) of the commutator; real and imag travel together
// as a packed {re, im} word.
module mdc_comm_pair #(
    parameter int nb    = 9,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            adv,
    input  logic            sel,
    input  logic [2*nb-1:0] u,
    input  logic [2*nb-1:0] l,
    output logic [2*nb-1:0] top,
    output logic [2*nb-1:0] bot
);
    logic [DEPTH-1:0][2*nb-1:0] dl_q;
    logic [DEPTH-1:0][2*nb-1:0] dt_q;
    logic [2*nb-1:0]            dl;
    logic [2*nb-1:0]            top_pre;

    assign dl      = dl_q[DEPTH-1];
    assign top_pre = sel ? dl : u;
    assign bot     = sel ? u : dl;
    assign top     = dt_q[DEPTH-1];

    // Two DEPTH-long shift lines: lower input, then switched upper path.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            dl_q <= '0;
            dt_q <= '0;
        end else if (adv) begin
            dl_q[0] <= l;
            dt_q[0] <= top_pre;
            for (int i = 1; i < DEPTH; i++) begin
                dl_q[i] <= dl_q[i-1];
                dt_q[i] <= dt_q[i-1];
            end
        end
    end
endmodule

module mdc_commutator #(
    parameter int nb    = 9,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          IN_VALID,
`ifdef MDC_COMM_BYPASS_EN
    input  logic          BYPASS,
`endif
    input  logic [nb*4-1:0] IR,
    input  logic [nb*4-1:0] II,
    output logic          OUT_VALID,
    output logic          OUT_START,
    output logic [nb*4-1:0] OR,
    output logic [nb*4-1:0] OI
);
    localparam int LW = $clog2(DEPTH);
    localparam int CW = LW + 1;

    logic [CW-1:0]     cnt_q, cnt_d, idx;
    logic              primed_q, primed_d;
    logic              started_q, started_d;
    logic              pend_q, pend_d;
    logic              ov_q, ov_d;
    logic              os_q, os_d;
    logic [nb*4-1:0]   or_q, or_d;
    logic [nb*4-1:0]   oi_q, oi_d;
    logic              sel;

    logic [1:0][2*nb-1:0] u_w, l_w, top_w, bot_w;

    // A START sample is always index 0 regardless of where cnt stood.
    assign idx = START ? '0 : cnt_q;
    assign sel = idx[LW];

    for (genvar p = 0; p < 2; p++) begin : g_pair
        assign u_w[p] = {IR[(2*p)*nb +: nb],   II[(2*p)*nb +: nb]};
        assign l_w[p] = {IR[(2*p+1)*nb +: nb], II[(2*p+1)*nb +: nb]};
        mdc_comm_pair #(.nb(nb), .DEPTH(DEPTH)) u_pair (
            .CLK (CLK),
            .RST (RST),
            .adv (IN_VALID),
            .sel (sel),
            .u   (u_w[p]),
            .l   (l_w[p]),
            .top (top_w[p]),
            .bot (bot_w[p])
        );
    end

    // Next-state: index counter, priming, start pulse and output word.
    always_comb begin
        cnt_d     = cnt_q;
        primed_d  = primed_q;
        started_d = started_q;
        pend_d    = pend_q;
        ov_d      = 1'b0;
        os_d      = 1'b0;
        or_d      = or_q;
        oi_d      = oi_q;
        if (IN_VALID) begin
            cnt_d = idx + 1'b1;
            if (START) begin
                started_d = 1'b1;
                pend_d    = 1'b1;
                primed_d  = (DEPTH == 1);
            end else if (started_q && idx == CW'(DEPTH - 1)) begin
                primed_d = 1'b1;
            end
            // The START accept itself always carries stale delay-line data.
            ov_d = primed_q & ~START;
            os_d = ov_d & pend_q;
            if (ov_d) pend_d = 1'b0;
            or_d = {bot_w[1][2*nb-1:nb], top_w[1][2*nb-1:nb],
                    bot_w[0][2*nb-1:nb], top_w[0][2*nb-1:nb]};
            oi_d = {bot_w[1][nb-1:0], top_w[1][nb-1:0],
                    bot_w[0][nb-1:0], top_w[0][nb-1:0]};
`ifdef MDC_COMM_BYPASS_EN
            if (BYPASS) begin
                ov_d = 1'b1;
                os_d = START;
                or_d = IR;
                oi_d = II;
            end
`endif
        end
    end

    // State and output registers; reset overrides everything on the same edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q     <= '0;
            primed_q  <= 1'b0;
            started_q <= 1'b0;
            pend_q    <= 1'b0;
            ov_q      <= 1'b0;
            os_q      <= 1'b0;
            or_q      <= '0;
            oi_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            primed_q  <= primed_d;
            started_q <= started_d;
            pend_q    <= pend_d;
            ov_q      <= ov_d;
            os_q      <= os_d;
            or_q      <= or_d;
            oi_q      <= oi_d;
        end
    end

    assign OUT_VALID = ov_q;
    assign OUT_START = os_q;
    assign OR        = or_q;
    assign OI        = oi_q;
endmodule

// File: tb/tb_mdc_commutator.sv
// Directed bench for mdc_commutator (DEPTH=4, nb=9). Sample n carries
// IR = {80+n, 64+n, 16+n, n}, II = IR + 128 per lane. Expected output order
// comes from the closed-form transpose: frame index k (since START), global
// accept count n; k%8 in 4..7 -> (U[n-4], U[n]), else (L[n-8], L[n-4]).
module tb_mdc_commutator;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [35:0] IR = '0;
    logic [35:0] II = '0;
    logic        OUT_VALID, OUT_START;
    logic [35:0] OR, OI;
`ifdef MDC_COMM_BYPASS_EN
    logic        BYPASS = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    int          n, k;
    bit          started, pend, exp_known;
    logic [35:0] exp_or, exp_oi;

    mdc_commutator #(.nb(9), .DEPTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .IN_VALID  (IN_VALID),
`ifdef MDC_COMM_BYPASS_EN
        .BYPASS    (BYPASS),
`endif
        .IR        (IR),
        .II        (II),
        .OUT_VALID (OUT_VALID),
        .OUT_START (OUT_START),
        .OR        (OR),
        .OI        (OI)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [35:0] mk(input int a0, input int a1, input int off);
        return {9'(a1 + 64 + off), 9'(a0 + 64 + off), 9'(a1 + off), 9'(a0 + off)};
    endfunction

    // One clock: drive sample n (if iv), advance the model, check after the edge.
    task automatic step(input bit st, input bit iv);
        bit ev, es;
        int a0, a1;
        START    = st;
        IN_VALID = iv;
        IR       = mk(n, 16 + n, 0);
        II       = mk(n, 16 + n, 128);
        ev = 1'b0;
        es = 1'b0;
        if (iv) begin
            if (st) begin
                k       = 0;
                started = 1'b1;
                pend    = 1'b1;
            end
            ev = started && (k >= 4);
            es = ev && pend;
            if (ev) pend = 1'b0;
            if (ev) begin
                if ((k % 8) >= 4) begin
                    a0 = n - 4;
                    a1 = n;
                end else begin
                    a0 = 16 + n - 8;
                    a1 = 16 + n - 4;
                end
                exp_or    = mk(a0, a1, 0);
                exp_oi    = mk(a0, a1, 128);
                exp_known = 1'b1;
            end else begin
                exp_known = 1'b0;
            end
            n++;
            k++;
        end
        @(posedge CLK);
        #1;
        chk("out_valid", 64'(OUT_VALID), 64'(ev));
        chk("out_start", 64'(OUT_START), 64'(es));
        if (exp_known) begin
            chk("or", 64'(OR), 64'(exp_or));
            chk("oi", 64'(OI), 64'(exp_oi));
        end
    endtask

    // Reset with START/IN_VALID high to show reset wins; outputs must be zero.
    task automatic do_reset(input int cyc);
        RST      = 1'b0;
        START    = 1'b1;
        IN_VALID = 1'b1;
        repeat (cyc) @(posedge CLK);
        #1;
        chk("rst_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_start", 64'(OUT_START), 64'd0);
        chk("rst_or", 64'(OR), 64'd0);
        chk("rst_oi", 64'(OI), 64'd0);
        RST       = 1'b1;
        START     = 1'b0;
        IN_VALID  = 1'b0;
        started   = 1'b0;
        pend      = 1'b0;
        exp_known = 1'b1;
        exp_or    = '0;
        exp_oi    = '0;
        k         = 0;
        n         = 0;
    endtask

    initial begin
        int acc, cyc;
        n = 0;
        k = 0;

        // Reset then 16-sample stream, then an idle cycle (hold check).
        do_reset(2);
        for (int i = 0; i < 16; i++) step(i == 0, 1'b1);
        step(1'b0, 1'b0);

        // Same stream with a bubble every third cycle.
        do_reset(1);
        acc = 0;
        cyc = 0;
        while (acc < 16) begin
            if ((cyc % 3) == 2) begin
                step(1'b0, 1'b0);
            end else begin
                step(acc == 0, 1'b1);
                acc++;
            end
            cyc++;
        end

        // START reasserted mid-frame at n=6.
        do_reset(1);
        for (int i = 0; i < 14; i++) step(i == 0 || i == 6, 1'b1);
        // START while idle must be ignored.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);

        // Reset at n=9; accepts without START stay invalid; then restart.
        do_reset(1);
        for (int i = 0; i < 9; i++) step(i == 0, 1'b1);
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        n = 0;
        for (int i = 0; i < 6; i++) step(i == 0, 1'b1);

        // Three back-to-back frames of 8 with START every 8 samples.
        do_reset(1);
        for (int i = 0; i < 24; i++) step((i % 8) == 0, 1'b1);

`ifdef MDC_COMM_BYPASS_EN
        // Bypass: output is previous accept's input with no priming gap.
        do_reset(1);
        BYPASS = 1'b1;
        for (int i = 0; i < 4; i++) begin
            START    = (i == 0);
            IN_VALID = 1'b1;
            IR       = mk(n, 16 + n, 0);
            II       = mk(n, 16 + n, 128);
            @(posedge CLK);
            #1;
            chk("byp_valid", 64'(OUT_VALID), 64'd1);
            chk("byp_start", 64'(OUT_START), 64'(i == 0));
            chk("byp_or", 64'(OR), 64'(mk(n, 16 + n, 0)));
            chk("byp_oi", 64'(OI), 64'(mk(n, 16 + n, 128)));
            n++;
        end
        BYPASS = 1'b0;
        do_reset(1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
